rot_pixel_pack: RTL

Downstream neighbour of the input pixel memory.
- Walks one square BGR tile in rotated (0/90/180/270) output order.
- Drives the memory's three per-channel read addresses and captures the returned B/G/R bytes one cycle later.
- Packs the 3-byte pixel stream into 32-bit words and delivers them to the write-back master over a valid/ready handshake.

---
 rtl/rpk_pkg.sv | 25 ++
 rtl/rpk_byte_fifo.sv | 56 +++++
 rtl/rot_pixel_pack.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rpk_pkg.sv
//------------------------------------------------------------------------------
// Module   : rpk_pkg
// Brief    : Shared constants and FSM encoding for rot_pixel_pack.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rpk_pkg;

  localparam logic [1:0] ROT_0   = 2'd0;
  localparam logic [1:0] ROT_90  = 2'd1;
  localparam logic [1:0] ROT_180 = 2'd2;
  localparam logic [1:0] ROT_270 = 2'd3;

  localparam int BYTES_PER_PIX = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rpk_state_e;

endpackage

`default_nettype wire

// File: rtl/rpk_byte_fifo.sv
//------------------------------------------------------------------------------
// Module   : rpk_byte_fifo
// Brief    : 8-byte pack buffer, 3-byte push and 4-byte pop, oldest byte lowest.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rpk_byte_fifo
  import rpk_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic [7:0]  b_i,
  input  logic [7:0]  g_i,
  input  logic [7:0]  r_i,
  input  logic        pop_i,
  output logic [31:0] word_o,
  output logic [3:0]  count_o
);

  logic [63:0] data_q, data_d;
  logic [3:0]  count_q, count_d;
  logic [3:0]  base;
  logic [63:0] shifted;
  logic [63:0] keep;

  // Bytes above the occupancy are masked off so a push can simply be OR-ed in.
  always_comb begin
    shifted = pop_i ? (data_q >> 32) : data_q;
    base    = pop_i ? (count_q - 4'd4) : count_q;
    keep    = ~({64{1'b1}} << {base, 3'b000});
    data_d  = shifted & keep;
    count_d = base;
    if (push_i) begin
      data_d  = data_d | ({40'd0, r_i, g_i, b_i} << {base, 3'b000});
      count_d = base + 4'(BYTES_PER_PIX);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign word_o  = data_q[31:0];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rot_pixel_pack.sv
//------------------------------------------------------------------------------
// Module   : rot_pixel_pack
// Brief    : Reads one BGR tile in rotated order and packs it into 32-bit words.
//            Optional horizontal mirror enabled by macro RPK_MIRROR_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rot_pixel_pack
  import rpk_pkg::*;
#(
  parameter int TILE_DIM = 4,
  parameter int ADDR_W   = 8
) (
  input  logic              I_RPK_HCLK,
  input  logic              I_RPK_HRESET_N,
  input  logic              I_RPK_START,
  input  logic [1:0]        I_RPK_ROT,
`ifdef RPK_MIRROR_EN
  input  logic              I_RPK_MIRROR,
`endif
  output logic [ADDR_W-1:0] O_RPK_ADDRB,
  output logic [ADDR_W-1:0] O_RPK_ADDRG,
  output logic [ADDR_W-1:0] O_RPK_ADDRR,
  input  logic [7:0]        I_RPK_PIXEL_B,
  input  logic [7:0]        I_RPK_PIXEL_G,
  input  logic [7:0]        I_RPK_PIXEL_R,
  output logic [31:0]       O_RPK_WDATA,
  output logic              O_RPK_WVALID,
  input  logic              I_RPK_WREADY,
  output logic              O_RPK_WLAST,
  output logic              O_RPK_BUSY,
  output logic              O_RPK_DONE
);

  localparam int NPIX  = TILE_DIM * TILE_DIM;
  localparam int WORDS = BYTES_PER_PIX * NPIX / 4;
  localparam int CW    = (TILE_DIM > 2) ? $clog2(TILE_DIM) : 1;
  localparam int KW    = $clog2(NPIX + 1);
  localparam int WW    = $clog2(WORDS + 1);
  localparam logic [7:0] DIM8  = 8'(TILE_DIM);
  localparam logic [7:0] LAST8 = 8'(TILE_DIM - 1);

  rpk_state_e    state_q, state_d;
  logic [1:0]    rot_q, rot_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [KW-1:0] k_q, k_d;
  logic [WW-1:0] word_q, word_d;
  logic          vld_q, vld_d;
`ifdef RPK_MIRROR_EN
  logic          mirror_q, mirror_d;
`endif

  logic [3:0]  fifo_cnt;
  logic [31:0] fifo_word;
  logic        wvalid, pop, issue, wlast;
  logic [4:0]  need, room;
  logic [7:0]  r8, c8, s8, a8;

  rpk_byte_fifo u_fifo (
    .clk_i   (I_RPK_HCLK),
    .rst_ni  (I_RPK_HRESET_N),
    .push_i  (vld_q),
    .b_i     (I_RPK_PIXEL_B),
    .g_i     (I_RPK_PIXEL_G),
    .r_i     (I_RPK_PIXEL_R),
    .pop_i   (pop),
    .word_o  (fifo_word),
    .count_o (fifo_cnt)
  );

  assign wvalid = (fifo_cnt >= 4'd4);
  assign pop    = wvalid && I_RPK_WREADY;
  assign wlast  = wvalid && (word_q == WW'(WORDS - 1));

  // Bytes already buffered plus those in flight plus the new pixel must fit.
  assign need  = 5'(fifo_cnt) + (vld_q ? 5'(BYTES_PER_PIX) : 5'd0) + 5'(BYTES_PER_PIX);
  assign room  = 5'd8 + (pop ? 5'd4 : 5'd0);
  assign issue = (state_q == ST_RUN) && (k_q != KW'(NPIX)) && (need <= room);

  always_comb begin
    r8 = 8'(row_q);
    c8 = 8'(col_q);
`ifdef RPK_MIRROR_EN
    if (mirror_q) c8 = LAST8 - 8'(col_q);
`endif
    case (rot_q)
      ROT_0:   s8 = r8 * DIM8 + c8;
      ROT_90:  s8 = (LAST8 - c8) * DIM8 + r8;
      ROT_180: s8 = (LAST8 - r8) * DIM8 + (LAST8 - c8);
      default: s8 = c8 * DIM8 + (LAST8 - r8);
    endcase
    a8 = s8 * 8'(BYTES_PER_PIX);
  end

  assign O_RPK_ADDRB  = (state_q != ST_IDLE) ? ADDR_W'(a8)        : '0;
  assign O_RPK_ADDRG  = (state_q != ST_IDLE) ? ADDR_W'(a8 + 8'd1) : '0;
  assign O_RPK_ADDRR  = (state_q != ST_IDLE) ? ADDR_W'(a8 + 8'd2) : '0;
  assign O_RPK_WDATA  = fifo_word;
  assign O_RPK_WVALID = wvalid;
  assign O_RPK_WLAST  = wlast;
  assign O_RPK_BUSY   = (state_q != ST_IDLE);
  assign O_RPK_DONE   = (state_q == ST_FLUSH);

  always_comb begin
    state_d  = state_q;
    rot_d    = rot_q;
    row_d    = row_q;
    col_d    = col_q;
    k_d      = k_q;
    vld_d    = issue;
    word_d   = word_q + WW'(pop);
`ifdef RPK_MIRROR_EN
    mirror_d = mirror_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_RPK_START) begin
          state_d  = ST_RUN;
          rot_d    = I_RPK_ROT;
          row_d    = '0;
          col_d    = '0;
          k_d      = '0;
          word_d   = '0;
`ifdef RPK_MIRROR_EN
          mirror_d = I_RPK_MIRROR;
`endif
        end
      end
      ST_RUN: begin
        if (issue) begin
          k_d = k_q + KW'(1);
          // Position is frozen on the final pixel so the addresses stay put.
          if (k_q != KW'(NPIX - 1)) begin
            if (col_q == CW'(TILE_DIM - 1)) begin
              col_d = '0;
              row_d = row_q + CW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
        if (pop && wlast) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_RPK_HCLK or negedge I_RPK_HRESET_N) begin
    if (!I_RPK_HRESET_N) begin
      state_q  <= ST_IDLE;
      rot_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      word_q   <= '0;
      vld_q    <= 1'b0;
`ifdef RPK_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rot_q    <= rot_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      word_q   <= word_d;
      vld_q    <= vld_d;
`ifdef RPK_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

endmodule

`default_nettype wire
